// File: rtl/video_timing_meter_pkg.sv
// video_timing_meter_pkg: shared axis state, count type and register map for video_timing_meter
package video_timing_meter_pkg;
    typedef enum logic [1:0] {ST_ACTIVE, ST_FP, ST_SYNC, ST_BP} axis_state_t;
    typedef logic [11:0] cnt12_t;
    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_HACT   = 4'd1;
    localparam logic [3:0] ADDR_HTOTAL = 4'd9;
    localparam logic [3:0] ADDR_CLK_HI = 4'd10;
    localparam logic [3:0] ADDR_CLK_LO = 4'd11;
    function automatic cnt12_t sat_inc12(input cnt12_t c);
        return (&c) ? c : c + 12'd1;
    endfunction
endpackage

// File: rtl/timing_axis_meter.sv
// timing_axis_meter: one sync/blank axis FSM with per-segment counters and exit latches
module timing_axis_meter
    import video_timing_meter_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clr,
    input  logic        i_ce,
    input  logic        i_sync,
    input  logic        i_blank,
    output logic        o_sync_rise,
    output logic [11:0] o_act,
    output logic [11:0] o_fp,
    output logic [11:0] o_sync,
    output logic [11:0] o_bp
);
    axis_state_t r_state, w_next;
    logic r_sync, r_blank;
    cnt12_t r_cnt;
    logic w_sync_fall, w_blank_rise, w_blank_fall;
    assign o_sync_rise  = i_ce & i_sync & ~r_sync;
    assign w_sync_fall  = i_ce & ~i_sync & r_sync;
    assign w_blank_rise = i_ce & i_blank & ~r_blank;
    assign w_blank_fall = i_ce & ~i_blank & r_blank;
    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) r_state <= ST_ACTIVE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = o_sync_rise                             ? ST_SYNC   :
                 (r_state == ST_ACTIVE && w_blank_rise)  ? ST_FP     :
                 (r_state == ST_SYNC   && w_sync_fall)   ? ST_BP     :
                 (r_state == ST_BP     && w_blank_fall)  ? ST_ACTIVE : r_state;
    end
    // The current pixel already belongs to the new segment, so a fresh count starts at 1
    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_sync  <= 1'b0;
            r_blank <= 1'b0;
            r_cnt   <= '0;
            o_act   <= '0;
            o_fp    <= '0;
            o_sync  <= '0;
            o_bp    <= '0;
        end else if (i_ce) begin
            r_sync  <= i_sync;
            r_blank <= i_blank;
            if (w_next != r_state) begin
                r_cnt <= 12'd1;
                case (r_state)
                    ST_ACTIVE: o_act  <= r_cnt;
                    ST_FP:     o_fp   <= r_cnt;
                    ST_SYNC:   o_sync <= r_cnt;
                    default:   o_bp   <= r_cnt;
                endcase
                if (w_next == ST_SYNC && r_state != ST_FP) o_fp <= '0;
            end else begin
                r_cnt <= sat_inc12(r_cnt);
            end
        end
    end
endmodule

// File: rtl/video_timing_meter.sv
// video_timing_meter: measures H/V video timing and exposes it as a register file
// Define VTIMING_CLKCOUNT_EN to add the clk-cycles-per-frame counter (registers 10-11).
module video_timing_meter
    import video_timing_meter_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pixel,
    input  logic        hsync,
    input  logic        hblank,
    input  logic        vsync,
    input  logic        vblank,
    input  logic [1:0]  wr,
    input  logic [3:0]  address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        frame_done,
    output logic        locked
);
    logic w_restart, w_h_rise, w_v_rise, w_copy, w_unused;
    logic r_armed, r_commit, r_locked, r_done;
    logic [7:0] r_frame_cnt;
    cnt12_t r_htot, r_htot_lat;
    logic [8:0][11:0] w_meas, r_regs;
    logic [31:0] w_clk_rd;
    assign w_restart = wr[0] && address == ADDR_STATUS && din[1];
    assign w_unused  = ^{wr[1], din[15:2], din[0]};
    assign w_copy    = r_commit && !w_restart;
    assign w_meas[8] = r_htot_lat;
    timing_axis_meter u_h (
        .clk(clk), .reset_n(reset_n), .i_clr(w_restart), .i_ce(ce_pixel),
        .i_sync(hsync), .i_blank(hblank), .o_sync_rise(w_h_rise),
        .o_act(w_meas[0]), .o_fp(w_meas[1]), .o_sync(w_meas[2]), .o_bp(w_meas[3])
    );
    // Vertical axis advances once per line, on the horizontal sync rise
    timing_axis_meter u_v (
        .clk(clk), .reset_n(reset_n), .i_clr(w_restart), .i_ce(w_h_rise),
        .i_sync(vsync), .i_blank(vblank), .o_sync_rise(w_v_rise),
        .o_act(w_meas[4]), .o_fp(w_meas[5]), .o_sync(w_meas[6]), .o_bp(w_meas[7])
    );
    always_ff @(posedge clk) begin
        if (!reset_n || w_restart) begin
            r_htot     <= '0;
            r_htot_lat <= '0;
        end else if (w_h_rise) begin
            r_htot_lat <= r_htot;
            r_htot     <= 12'd1;
        end else if (ce_pixel) begin
            r_htot <= sat_inc12(r_htot);
        end
    end
    // The first vsync rise after reset/restart only arms; the partial frame before it is dropped
    always_ff @(posedge clk) begin
        if (!reset_n || w_restart) begin
            r_armed     <= 1'b0;
            r_commit    <= 1'b0;
            r_locked    <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_armed  <= r_armed | w_v_rise;
            r_commit <= w_v_rise & r_armed;
            r_done   <= w_copy;
            if (w_copy) begin
                r_locked    <= (w_meas == r_regs);
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) r_regs <= '0;
        else if (w_copy) r_regs <= w_meas;
    end
`ifdef VTIMING_CLKCOUNT_EN
    logic [31:0] r_clk_cnt, r_clk_lat, r_clk_rd;
    always_ff @(posedge clk) begin
        if (!reset_n) r_clk_rd <= '0;
        else if (w_copy) r_clk_rd <= r_clk_lat;
        if (!reset_n || w_restart) begin
            r_clk_cnt <= '0;
            r_clk_lat <= '0;
        end else if (w_v_rise) begin
            r_clk_lat <= r_clk_cnt;
            r_clk_cnt <= 32'd1;
        end else if (!(&r_clk_cnt)) begin
            r_clk_cnt <= r_clk_cnt + 32'd1;
        end
    end
    assign w_clk_rd = r_clk_rd;
`else
    assign w_clk_rd = '0;
`endif
    assign frame_done = r_done;
    assign locked     = r_locked;
    assign dout = (address == ADDR_STATUS) ? {r_frame_cnt, 7'd0, r_locked} :
                  (address <= ADDR_HTOTAL) ? {4'd0, r_regs[address - ADDR_HACT]} :
                  (address == ADDR_CLK_HI) ? w_clk_rd[31:16] :
                  (address == ADDR_CLK_LO) ? w_clk_rd[15:0] : 16'd0;
endmodule

// File: tb/tb_video_timing_meter.sv
// tb_video_timing_meter: scoreboard bench for video_timing_meter
// Reduced raster h 64/4/8/6 (total 82), v 8/2/1/3 (14 lines), ce every 2nd clk.
module tb_video_timing_meter;
    typedef logic [11:0][15:0] snap_t;
    typedef struct packed {
        logic [11:0] m;
        snap_t       v;
    } exp_t;

    logic clk = 0, reset_n = 0, ce_pixel = 0;
    logic hsync = 0, hblank = 0, vsync = 0, vblank = 0;
    logic [1:0]  wr = 0;
    logic [3:0]  address = 0;
    logic [15:0] din = 0;
    logic [15:0] dout;
    logic frame_done, locked;
    int n_pass = 0, n_total = 0, n_done = 0;
    exp_t sb[$];

    video_timing_meter dut (
        .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel),
        .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
        .wr(wr), .address(address), .din(din),
        .dout(dout), .frame_done(frame_done), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic compare_regs(input string tag, input exp_t e);
        for (int k = 0; k < 12; k++) begin
            if (e.m[k]) begin
                address = 4'(k);
                #1;
                check($sformatf("%s reg%0d", tag, k), {16'd0, dout}, {16'd0, e.v[k]});
            end
        end
        check({tag, " locked"}, {31'd0, locked}, {31'd0, e.v[0][0]});
    endtask

    // hfp, htotal and clocks/frame are hand-computed per raster variant
    function automatic exp_t mk(input logic [15:0] hfp, input logic [15:0] htot,
                                input logic [31:0] clks, input logic [7:0] fc, input logic lk);
        exp_t e;
        e.m = '1;
        e.v = '0;
        e.v[0] = {fc, 7'd0, lk};
        e.v[1] = 16'd64;
        e.v[2] = hfp;
        e.v[3] = 16'd8;
        e.v[4] = 16'd6;
        e.v[5] = 16'd8;
        e.v[6] = 16'd2;
        e.v[7] = 16'd1;
        e.v[8] = 16'd3;
        e.v[9] = htot;
`ifdef VTIMING_CLKCOUNT_EN
        e.v[10] = clks[31:16];
        e.v[11] = clks[15:0];
`else
        e.v[10] = 16'd0 & clks[31:16];
        e.v[11] = 16'd0 & clks[15:0];
`endif
        return e;
    endfunction

    task automatic push(input exp_t e);
        sb.push_back(e);
    endtask

    task automatic pix(input logic hs, input logic hb);
        hsync = hs;
        hblank = hb;
        ce_pixel = 1;
        @(posedge clk) #1;
        ce_pixel = 0;
        @(posedge clk) #1;
    endtask

    task automatic line(input int hf, input logic vs, input logic vb);
        vsync = vs;
        vblank = vb;
        for (int i = 0; i < 8; i++) pix(1, 1);
        for (int i = 0; i < 6; i++) pix(0, 1);
        for (int i = 0; i < 64; i++) pix(0, 0);
        for (int i = 0; i < hf; i++) pix(0, 1);
    endtask

    task automatic frame_lines(input int hf, input int first, input int last);
        for (int l = first; l <= last; l++) line(hf, l == 0, l < 4 || l >= 12);
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        wr = 2'b01;
        address = a;
        din = d;
        @(posedge clk) #1;
        wr = 2'b00;
        din = 16'd0;
    endtask

    always @(negedge clk) if (frame_done) n_done++;

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) begin
                if (sb.size() == 0) check("spurious frame_done", 32'(sb.size()), 32'd1);
                else compare_regs("commit", sb.pop_front());
            end
        end
    end

    initial begin
        exp_t z, s;
        z.m = '1;
        z.v = '0;
        repeat (3) @(posedge clk);
        #1;
        compare_regs("reset", z);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        reset_n = 1;
        frame_lines(4, 0, 13);
        push(mk(16'd4, 16'd82, 32'd2296, 8'd1, 1'b0));
        frame_lines(4, 0, 13);
        push(mk(16'd4, 16'd82, 32'd2296, 8'd2, 1'b1));
        frame_lines(4, 0, 13);
        push(mk(16'd4, 16'd82, 32'd2296, 8'd3, 1'b1));
        frame_lines(4, 0, 13);
        push(mk(16'd4, 16'd82, 32'd2296, 8'd4, 1'b1));
        frame_lines(24, 0, 13);
        push(mk(16'd24, 16'd102, 32'd2856, 8'd5, 1'b0));
        frame_lines(24, 0, 13);
        push(mk(16'd24, 16'd102, 32'd2856, 8'd6, 1'b1));
        frame_lines(4, 0, 13);
        push(mk(16'd4, 16'd82, 32'd2296, 8'd7, 1'b0));
        frame_lines(4, 0, 5);
        write(4'd1, 16'hFFFF);
        compare_regs("ignored write", mk(16'd4, 16'd82, 32'd2296, 8'd7, 1'b0));
        write(4'd0, 16'h0002);
        compare_regs("restart", mk(16'd4, 16'd82, 32'd2296, 8'd0, 1'b0));
        frame_lines(4, 6, 13);
        frame_lines(24, 0, 13);
        push(mk(16'd24, 16'd102, 32'd2856, 8'd1, 1'b0));
        frame_lines(4, 0, 3);
        reset_n = 0;
        @(posedge clk) #1;
        reset_n = 1;
        compare_regs("mid reset", z);
        frame_lines(4, 4, 13);
        frame_lines(4, 0, 13);
        push(mk(16'd4, 16'd82, 32'd2296, 8'd1, 1'b0));
        frame_lines(4, 0, 0);
        repeat (30) @(posedge clk);
        #1;
        hsync = 0;
        hblank = 0;
        vsync = 0;
        vblank = 0;
        write(4'd0, 16'h0002);
        s.m = 12'b1110_0000_0011;
        s.v = '0;
        s.v[0] = 16'h0100;
        s.v[1] = 16'd4095;
        s.v[9] = 16'd4095;
`ifdef VTIMING_CLKCOUNT_EN
        s.v[11] = 16'd10000;
`endif
        push(s);
        for (int p = 1; p <= 15000; p++) begin
            hsync = (p % 5000 == 0);
            vsync = (p < 10000) || (p >= 15000);
            ce_pixel = 1;
            @(posedge clk) #1;
        end
        ce_pixel = 0;
        hsync = 0;
        repeat (30) @(posedge clk);
        #1;
        check("frame_done pulses", 32'(n_done), 32'd10);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/video_timing_meter.md
VIDEO_TIMING_METER -- requirements
Module: video_timing_meter

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset.
REQ-003 ce_pixel  in  1  pixel clock enable; sync/blank inputs are sampled only when high.
REQ-004 hsync, hblank, vsync, vblank  in  1 each  active-high video timing under test.
REQ-005 wr  in  2  byte write strobes; only wr[0] is used.
REQ-006 address  in  4  register select.
REQ-007 din  in  16  write data.
REQ-008 dout  out  16  combinational read of the register at address.
REQ-009 frame_done  out  1  one-clk pulse on each frame commit.
REQ-010 locked  out  1  mirrors status bit 0.

Function
REQ-011 Register map: 0 status {locked[0], restart[1] write-only reads 0, frame_cnt[15:8]}; 1 hact; 2 hfp; 3 hs; 4 hbp; 5 vact; 6 vfp; 7 vs; 8 vbp; 9 htotal; 10 clocks/frame [31:16]; 11 clocks/frame [15:0]; 12-15 read 0.
REQ-012 Writes: wr[0], address 0 and din[1]=1 trigger restart; all other writes are ignored.
REQ-013 Horizontal FSM states H_ACTIVE, H_FP, H_SYNC, H_BP, advanced only on ce_pixel.
REQ-014 H transitions: ACTIVE->FP on hblank rise; FP->SYNC on hsync rise; SYNC->BP on hsync fall; BP->ACTIVE on hblank fall.
REQ-015 hsync rise in any state goes to H_SYNC; a skipped FP latches hfp=0.
REQ-016 Each H state counts pixels in a 12-bit counter saturating at 4095; the counter is latched into its line register on state exit, then cleared.
REQ-017 htotal = pixels between consecutive hsync rises, 12-bit, saturating.
REQ-018 Vertical FSM states V_ACTIVE, V_FP, V_SYNC, V_BP follow the same rules with vblank/vsync, evaluated and counted once per line at each hsync rise.
REQ-019 Commit: on the ce_pixel at which a vsync rise is sampled, the next clk copies all line/frame registers to the readable registers 1-11, pulses frame_done and increments frame_cnt (8-bit wrap).
REQ-020 Lock: at commit, locked=1 iff registers 1-9 equal the previous commit; otherwise locked=0.
REQ-021 Clocks/frame: a 32-bit clk-cycle counter between vsync rises, saturating at 0xFFFFFFFF.
REQ-022 Restart returns both FSMs to ACTIVE, clears counters, locked and frame_cnt, and leaves registers 1-11 unchanged.
REQ-023 Simultaneous restart and commit: restart wins and no frame_done is issued.
REQ-024 Edge detect uses inputs registered on ce_pixel; there are no edges when ce_pixel is low.

Reset
REQ-025 reset_n low: FSMs go to ACTIVE; all counters and registers 1-11 read 0; locked=0; frame_cnt=0; frame_done=0.
REQ-026 Reset mid-frame discards the partial frame; the first commit occurs at the second vsync rise after release.

Configuration
REQ-027 With VTIMING_CLKCOUNT_EN defined, the clocks/frame counter and registers 10-11 exist.
REQ-028 Without VTIMING_CLKCOUNT_EN, the counter is absent and registers 10-11 read 0.

Structure
REQ-029 A shared package holds the H/V state enum, register address constants and the 12-bit count type.
REQ-030 One sub-module, timing_axis_meter, is instantiated twice (H with ce_pixel; V with the line strobe) and contains the FSM, segment counters and latches.

Verification
REQ-031 Drive 640x480 (h 640/16/96/48, v 480/10/2/33, ce every 2nd clk) -> after the 2nd commit regs 1-9 = 640,16,96,48,480,10,2,33,800; regs 10/11 = 0x000C/0xD140.
REQ-032 Same stimulus, 3 commits -> locked 0,1,1; frame_cnt=3; exactly 3 frame_done pulses.
REQ-033 Change hfp to 24 for one frame -> that commit gives hfp=24, locked=0; the next identical frame gives locked=1.
REQ-034 Hold hblank low, pulse hsync every 5000 pixels -> hact=4095, htotal=4095 at commit.
REQ-035 Write 0x0002 to addr 0 mid-frame -> locked=0, frame_cnt=0, regs 1-11 unchanged; next valid commit repopulates them.
REQ-036 Assert reset_n=0 for 1 clk mid-frame -> all regs read 0; first frame_done at the 2nd vsync rise after release.
